// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// lsu_pkg : shared types and helpers for the dmem_lsu load/store unit
// Rev 1.0
// ============================================================================
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_t;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;
  localparam logic [3:0] BE_NONE = 4'b0000;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } sb_entry_t;

  function automatic logic [3:0] size_to_be(input size_t size);
    case (size)
      SZ_BYTE: return BE_BYTE;
      SZ_HALF: return BE_HALF;
      SZ_WORD: return BE_WORD;
      default: return BE_NONE;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] raw, input size_t size,
                                              input logic sgn);
    case (size)
      SZ_BYTE: return {{24{sgn & raw[7]}}, raw[7:0]};
      SZ_HALF: return {{16{sgn & raw[15]}}, raw[15:0]};
      SZ_WORD: return raw;
      default: return 32'h0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/store_buffer_fifo.sv
`default_nettype none
// ============================================================================
// store_buffer_fifo : circular store buffer with a per-slot valid/addr view
// Rev 1.0
// ============================================================================
module store_buffer_fifo
  import lsu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  sb_entry_t                  push_entry,
  input  logic                       pop,
  output sb_entry_t                  head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic [$clog2(DEPTH)-1:0]   head_idx,
  output logic [DEPTH-1:0]           entry_valid,
  output sb_entry_t [DEPTH-1:0]      entries
);

  localparam int PW = $clog2(DEPTH);

  sb_entry_t [DEPTH-1:0] slots;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        slots[wr_ptr] <= push_entry;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  assign full     = (count == (PW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign head     = slots[rd_ptr];
  assign head_idx = rd_ptr;
  assign entries  = slots;

  // A slot is live when its distance from the head is below the occupancy.
  for (genvar i = 0; i < DEPTH; i++) begin : g_valid
    logic [PW-1:0] age;
    assign age            = PW'(i) - rd_ptr;
    assign entry_valid[i] = ({1'b0, age} < count);
  end

endmodule
`default_nettype wire

// File: rtl/dmem_lsu.sv
`default_nettype none
// ============================================================================
// dmem_lsu : MEM-stage load/store unit owning the data-memory port.
// Optional store-to-load forwarding enabled by defining SB_FORWARD_EN.
// Rev 1.0
// ============================================================================
module dmem_lsu
  import lsu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int BITS  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [1:0]      req_size,
  input  logic            req_signed,
  input  logic [31:0]     req_addr,
  input  logic [BITS-1:0] req_wdata,
  output logic            resp_valid,
  output logic [BITS-1:0] resp_rdata,
  output logic            sb_empty,
  output logic [31:0]     mem_addr,
  output logic [BITS-1:0] mem_wdata,
  output logic            mem_rw_,
  output logic [3:0]      mem_byte_en,
  input  logic [BITS-1:0] mem_rdata
);

  localparam int PW = $clog2(DEPTH);

`ifdef SB_FORWARD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  size_t                 size;
  sb_entry_t             push_entry;
  sb_entry_t             head;
  logic                  full;
  logic                  empty;
  logic [PW:0]           count;
  logic [PW-1:0]         head_idx;
  logic [DEPTH-1:0]      entry_valid;
  sb_entry_t [DEPTH-1:0] entries;
  logic [DEPTH-1:0]      addr_match;
  logic                  hazard;
  logic                  fwd_hit;
  sb_entry_t             fwd_entry;
  logic                  fwd_ok;
  logic                  load_acc;
  logic                  store_push;
  logic                  port_load;
  logic                  drain;

  assign size       = size_t'(req_size);
  assign push_entry = '{addr: req_addr, data: req_wdata, be: size_to_be(size)};

  store_buffer_fifo #(.DEPTH(DEPTH)) u_sb (
    .clk         (clk),
    .rst         (rst),
    .push        (store_push),
    .push_entry  (push_entry),
    .pop         (drain),
    .head        (head),
    .full        (full),
    .empty       (empty),
    .count       (count),
    .head_idx    (head_idx),
    .entry_valid (entry_valid),
    .entries     (entries)
  );

  for (genvar i = 0; i < DEPTH; i++) begin : g_match
    assign addr_match[i] = entry_valid[i] && (entries[i].addr == req_addr);
  end
  assign hazard = |addr_match;

  // Walk oldest to youngest so the last hit is the youngest matching store.
  always_comb begin
    logic [PW-1:0] idx;
    idx       = '0;
    fwd_hit   = 1'b0;
    fwd_entry = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_idx + PW'(k);
      if (addr_match[idx]) begin
        fwd_hit   = 1'b1;
        fwd_entry = entries[idx];
      end
    end
  end

  assign fwd_ok = FWD_EN && fwd_hit && ((size_to_be(size) & ~fwd_entry.be) == 4'b0000);

  always_comb begin
    req_ready = 1'b0;
    if (!rst) begin
      if (req_we) req_ready = !full;
      else        req_ready = !hazard || fwd_ok;
    end
  end

  assign load_acc   = req_valid && req_ready && !req_we;
  assign store_push = req_valid && req_ready && req_we && (size != SZ_ILL);
  assign port_load  = load_acc && !hazard;
  assign drain      = !rst && (count != '0) && !port_load;
  assign sb_empty   = empty;

  always_comb begin
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_rw_     = 1'b1;
    mem_byte_en = BE_NONE;
    if (port_load) begin
      mem_addr = req_addr;
    end else if (drain) begin
      mem_addr    = head.addr;
      mem_wdata   = head.data;
      mem_rw_     = 1'b0;
      mem_byte_en = head.be;
    end
  end

  // A load accepted with a buffered match can only be a forwarded one.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= load_acc;
      if (load_acc) begin
        resp_rdata <= load_extend(hazard ? fwd_entry.data : mem_rdata, size, req_signed);
      end
    end
  end

endmodule
`default_nettype wire
